// File: rtl/lc4_seq_alu_pkg.sv
// Shared opcode constants, operation/state encodings and the instruction decoder
// for the LC4 multi-cycle arithmetic unit.
package lc4_seq_alu_pkg;

  localparam logic [3:0] OPC_ARITH     = 4'b0001;
  localparam logic [3:0] OPC_SHIFT_MOD = 4'b1010;

  typedef enum logic [2:0] {OP_ADD, OP_MUL, OP_SUB, OP_DIV, OP_ADDI, OP_MOD, OP_ILLEGAL} op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic {MODE_MUL, MODE_DIV} mode_e;

  function automatic op_e decode_op(input logic [15:0] insn);
    op_e op;
    op = OP_ILLEGAL;
    if (insn[15:12] == OPC_ARITH) begin
      if (insn[5]) begin
        op = OP_ADDI;
      end else begin
        case (insn[4:3])
          2'b00:   op = OP_ADD;
          2'b01:   op = OP_MUL;
          2'b10:   op = OP_SUB;
          default: op = OP_DIV;
        endcase
      end
    end else if (insn[15:12] == OPC_SHIFT_MOD && insn[5:4] == 2'b11) begin
      op = OP_MOD;
    end
    return op;
  endfunction

endpackage

// File: rtl/lc4_iter_muldiv.sv
// Iterative engine: LSB-first shift-add multiply or MSB-first restoring divide,
// one bit per cycle for WORD_SIZE cycles; results are presented with the last step.
module lc4_iter_muldiv
  import lc4_seq_alu_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = $clog2(WORD_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  mode_e                mode,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic                 done,
  output logic [WORD_SIZE-1:0] product,
  output logic [WORD_SIZE-1:0] quotient,
  output logic [WORD_SIZE-1:0] remainder
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_SIZE - 1);

  logic                 busy;
  logic [CNT_W-1:0]     cnt;
  mode_e                mode_q;
  // acc: product accumulator / partial remainder; opb: multiplicand / divisor;
  // shr: multiplier / dividend shifting into quotient
  logic [WORD_SIZE-1:0] acc, opb, shr;
  logic [WORD_SIZE-1:0] acc_nxt, opb_nxt, shr_nxt;
  logic [WORD_SIZE:0]   rem_sh;
  logic                 fits;

  always_comb begin
    acc_nxt = acc;
    opb_nxt = opb;
    shr_nxt = shr;
    rem_sh  = {acc, shr[WORD_SIZE-1]};
    fits    = rem_sh >= {1'b0, opb};
    if (mode_q == MODE_MUL) begin
      if (shr[0]) acc_nxt = acc + opb;
      opb_nxt = opb << 1;
      shr_nxt = shr >> 1;
    end else begin
      acc_nxt = fits ? WORD_SIZE'(rem_sh - {1'b0, opb}) : rem_sh[WORD_SIZE-1:0];
      shr_nxt = {shr[WORD_SIZE-2:0], fits};
    end
  end

  assign done      = busy && (cnt == LAST);
  assign product   = acc_nxt;
  assign quotient  = shr_nxt;
  assign remainder = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mode_q <= MODE_MUL;
      acc    <= '0;
      opb    <= '0;
      shr    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mode_q <= mode;
      acc    <= '0;
      opb    <= (mode == MODE_MUL) ? a : b;
      shr    <= (mode == MODE_MUL) ? b : a;
    end else if (busy) begin
      acc <= acc_nxt;
      opb <= opb_nxt;
      shr <= shr_nxt;
      if (cnt == LAST) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc4_seq_alu.sv
// LC4 multi-cycle arithmetic unit: decode, valid/ready FSM, single-cycle
// add/sub/addi and registered result, with MUL/DIV/MOD handed to the engine.
module lc4_seq_alu
  import lc4_seq_alu_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = $clog2(WORD_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [15:0]          i_insn,
  input  logic [WORD_SIZE-1:0] i_r1data,
  input  logic [WORD_SIZE-1:0] i_r2data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_result,
  output logic                 o_dbz,
  output logic                 o_illegal
);

  state_e               state;
  op_e                  op, op_q;
  logic                 accept, is_div, dbz, iter_go, eng_start, eng_done;
  logic [WORD_SIZE-1:0] imm, single_res, eng_res, product, quotient, remainder;

  assign op        = decode_op(i_insn);
  assign accept    = i_valid && (state == S_IDLE);
  assign is_div    = (op == OP_DIV) || (op == OP_MOD);
  assign dbz       = is_div && (i_r2data == '0);
  assign iter_go   = (op == OP_MUL) || (is_div && !dbz);
  assign eng_start = accept && iter_go && !rst;
  assign imm       = WORD_SIZE'($signed(i_insn[4:0]));

  always_comb begin
    single_res = '0;
    case (op)
      OP_ADD:  single_res = i_r1data + i_r2data;
      OP_SUB:  single_res = i_r1data - i_r2data;
      OP_ADDI: single_res = i_r1data + imm;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    eng_res = remainder;
    if (op_q == OP_MUL)      eng_res = product;
    else if (op_q == OP_DIV) eng_res = quotient;
  end

  lc4_iter_muldiv #(.WORD_SIZE(WORD_SIZE), .CNT_W(CNT_W)) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .mode      ((op == OP_MUL) ? MODE_MUL : MODE_DIV),
    .a         (i_r1data),
    .b         (i_r2data),
    .done      (eng_done),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_ADD;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_dbz     <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q    <= op;
          o_ready <= 1'b0;
          if (iter_go) begin
            state <= S_CALC;
          end else begin
            state     <= S_DONE;
            o_valid   <= 1'b1;
            o_result  <= single_res;
            o_dbz     <= dbz;
            o_illegal <= (op == OP_ILLEGAL);
          end
        end
        S_CALC: if (eng_done) begin
          state     <= S_DONE;
          o_valid   <= 1'b1;
          o_result  <= eng_res;
          o_dbz     <= 1'b0;
          o_illegal <= 1'b0;
        end
        S_DONE: if (i_ready) begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_seq_alu.sv
// Directed table-driven bench for lc4_seq_alu plus backpressure and reset sequences.
module tb_lc4_seq_alu;

  localparam int W = 16;

  logic         clk, rst, i_valid, o_ready, i_ready, o_valid, o_dbz, o_illegal;
  logic [15:0]  i_insn;
  logic [W-1:0] i_r1data, i_r2data, o_result;

  int checks = 0;
  int errors = 0;

  lc4_seq_alu #(.WORD_SIZE(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_insn    (i_insn),
    .i_r1data  (i_r1data),
    .i_r2data  (i_r2data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_dbz     (o_dbz),
    .o_illegal (o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [15:0]  insn;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic [W-1:0] res;
    logic         dbz;
    logic         ill;
    int           lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Waits at negedges for o_valid; lat=1 is the cycle right after the accept edge.
  task automatic wait_valid(input string name, output int lat);
    lat = 1;
    while (!o_valid && lat < 40) begin
      check({name, " ready low while busy"}, o_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check({name, " valid seen"}, o_valid, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    check({v.name, " ready before"}, o_ready, 1'b1);
    i_valid  = 1'b1;
    i_insn   = v.insn;
    i_r1data = v.r1;
    i_r2data = v.r2;
    @(posedge clk);
    @(negedge clk);
    i_valid  = 1'b0;
    i_insn   = 16'h1018;
    i_r1data = W'($urandom);
    i_r2data = W'($urandom);
    wait_valid(v.name, lat);
    check({v.name, " latency"}, lat, v.lat);
    check({v.name, " result"}, o_result, v.res);
    check({v.name, " dbz"}, o_dbz, v.dbz);
    check({v.name, " illegal"}, o_illegal, v.ill);
    @(posedge clk);
    @(negedge clk);
    check({v.name, " valid drops"}, o_valid, 1'b0);
    check({v.name, " ready back"}, o_ready, 1'b1);
  endtask

  initial begin
    int   lat;
    logic [W-1:0] held;
    logic seen;

    vecs[0]  = '{"add",       16'h1000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1};
    vecs[1]  = '{"sub",       16'h1010, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1};
    vecs[2]  = '{"mul",       16'h1008, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0, 17};
    vecs[3]  = '{"mul max",   16'h1008, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17};
    vecs[4]  = '{"div",       16'h1018, 16'd100,  16'd7,    16'h000E, 1'b0, 1'b0, 17};
    vecs[5]  = '{"mod",       16'hA030, 16'd100,  16'd7,    16'h0002, 1'b0, 1'b0, 17};
    vecs[6]  = '{"div by 1",  16'h1018, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 17};
    vecs[7]  = '{"div dbz",   16'h1018, 16'd100,  16'h0000, 16'h0000, 1'b1, 1'b0, 1};
    vecs[8]  = '{"mod dbz",   16'hA030, 16'd100,  16'h0000, 16'h0000, 1'b1, 1'b0, 1};
    vecs[9]  = '{"and illeg", 16'h5000, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1};
    vecs[10] = '{"addi",      16'h103D, 16'h0005, 16'hAAAA, 16'h0002, 1'b0, 1'b0, 1};
    vecs[11] = '{"mod 2",     16'hA030, 16'h1234, 16'h0100, 16'h0034, 1'b0, 1'b0, 17};
    vecs[12] = '{"div 2",     16'h1018, 16'h8000, 16'h0003, 16'h2AAA, 1'b0, 1'b0, 17};
    vecs[13] = '{"mul 2",     16'h1008, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 17};
    vecs[14] = '{"shift ill", 16'hA000, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
    vecs[15] = '{"add wrap",  16'h1000, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b0, 1};

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_insn = 16'h0000; i_r1data = '0; i_r2data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset valid", o_valid, 1'b0);
    check("reset ready", o_ready, 1'b1);
    check("reset result", o_result, 16'h0000);
    check("reset dbz", o_dbz, 1'b0);
    check("reset illegal", o_illegal, 1'b0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Backpressure: result held in DONE, concurrent ADD refused until release
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1;
    i_insn = 16'h1008; i_r1data = 16'h0003; i_r2data = 16'h0005;
    @(posedge clk);
    @(negedge clk);
    i_insn = 16'h1000; i_r1data = 16'h0001; i_r2data = 16'h0002;
    wait_valid("bp mul", lat);
    check("bp latency", lat, 17);
    check("bp result", o_result, 16'h000F);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp hold result", o_result, 16'h000F);
      check("bp hold valid", o_valid, 1'b1);
      check("bp hold ready", o_ready, 1'b0);
    end
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release valid", o_valid, 1'b0);
    check("bp release ready", o_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("bp add valid", o_valid, 1'b1);
    check("bp add result", o_result, 16'h0003);
    @(posedge clk);

    // Reset during CALC discards the multiply
    @(negedge clk);
    i_valid = 1'b1; i_insn = 16'h1008; i_r1data = 16'h0123; i_r2data = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("calc no valid", o_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst valid", o_valid, 1'b0);
    check("rst ready", o_ready, 1'b1);
    check("rst result", o_result, 16'h0000);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    check("rst no late valid", seen, 1'b0);
    run_vec(vecs[10]);

    // Reset together with i_valid: request refused
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b1; i_insn = 16'h1000; i_r1data = 16'h0004; i_r2data = 16'h0004;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    check("rst+valid no accept", o_valid, 1'b0);
    check("rst+valid ready", o_ready, 1'b1);
    held = o_result;
    @(posedge clk);
    @(negedge clk);
    check("rst+valid still idle", o_valid, 1'b0);
    check("rst+valid result", held, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc4_seq_alu.md
# lc4_seq_alu

Multi-cycle, parametrised arithmetic unit for the LC4 datapath. It executes the ARITH group (ADD, MUL, SUB, DIV, ADDI) and MOD through a valid/ready handshake. Single-cycle ops return in one cycle. MUL, DIV and MOD run on an iterative engine for WORD_SIZE cycles, which replaces the stubbed multiplier path. It sits beside the combinational ALU and is selected by the decode stage for opcode 0001 and for 1010 with insn[5:4]=11.

## Interface
- WORD_SIZE, 16, datapath width (≥4).
- CNT_W, $clog2(WORD_SIZE+1), iteration counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  unit can accept a request
- i_insn  in  16  LC4 instruction
- i_r1data  in  WORD_SIZE  rs operand
- i_r2data  in  WORD_SIZE  rt operand
- o_valid  out  1  result valid
- i_ready  in  1  consumer takes result
- o_result  out  WORD_SIZE  result
- o_dbz  out  1  divide-by-zero flag, qualified by o_valid
- o_illegal  out  1  unsupported instruction, qualified by o_valid

## Operation
- Accept when i_valid && o_ready. Capture insn and operands on accept; later input changes are ignored.
- Decode for opcode 0001, by insn[5:3]:
  - 000 ADD: r1+r2.
  - 001 MUL: low WORD_SIZE bits of r1*r2.
  - 010 SUB: r1−r2.
  - 011 DIV: unsigned r1/r2.
  - 1xx ADDI: r1 + sign-extended imm5 (insn[4:0]).
- Opcode 1010 with insn[5:4]=11: MOD, unsigned r1 % r2.
- Any other instruction: result 0, o_illegal=1, single-cycle.
- All add/sub wrap modulo 2^WORD_SIZE.
- MUL uses shift-add, one multiplier bit per cycle, LSB first.
- DIV/MOD use restoring division, one quotient bit per cycle, MSB first. DIV returns the quotient; MOD returns the remainder.
- Divide by zero (DIV or MOD with r2=0): skip iteration, result 0, o_dbz=1.
- FSM:
  - IDLE: accept → CALC for MUL, or DIV/MOD with r2≠0; otherwise → DONE.
  - CALC: counter counts 0..WORD_SIZE−1; at the last count → DONE.
  - DONE: o_valid=1; i_ready → IDLE.
- o_ready = (state==IDLE). Requests during CALC/DONE are not accepted.
- o_result, o_dbz and o_illegal are registered and held stable throughout DONE until the handshake.

## Timing
- Reset values: state IDLE, o_valid 0, o_ready 1, o_result 0, o_dbz 0, o_illegal 0, counter 0, engine registers 0.
- Latency is measured from the accept edge N:
  - single-cycle ops, illegal, dbz: o_valid at N+1.
  - MUL/DIV/MOD: o_valid at N+WORD_SIZE+1.
- Throughput, with i_ready held high: one single-cycle op per 2 cycles; one iterative op per WORD_SIZE+2 cycles.
- Backpressure: if i_ready=0, the unit stays in DONE indefinitely with outputs unchanged.
- rst in any state wins at the next edge. An in-flight operation is discarded and no o_valid is produced for it.
- rst asserted together with i_valid: the request is not accepted.
- The result is dropped only by a handshake (o_valid && i_ready); o_valid deasserts the cycle after.

## Structure
- Package lc4_seq_alu_pkg:
  - opcode constants OPC_ARITH=4'b0001, OPC_SHIFT_MOD=4'b1010;
  - op enum {OP_ADD, OP_MUL, OP_SUB, OP_DIV, OP_ADDI, OP_MOD, OP_ILLEGAL};
  - state enum {S_IDLE, S_CALC, S_DONE}.
- Sub-module lc4_iter_muldiv (WORD_SIZE):
  - start, mode (mul/div), a, b in; done, product, quotient, remainder out.
  - Owns the counter and the shift registers.
- Top level owns decode, FSM, single-cycle arithmetic and output registers.

## Test plan
- ADD (insn 0x1000) r1=0x7FFF r2=0x0001 → o_result 0x8000 at N+1, o_illegal 0, o_dbz 0; SUB (0x1010) 0x0000−0x0001 → 0xFFFF.
- MUL (0x1008) 0x0123×0x0010 → 0x1230 at N+17; 0xFFFF×0xFFFF → 0x0001; o_ready low on cycles N+1..N+17.
- DIV (0x1018) 100/7 → 0x000E at N+17; MOD (0xA030) 100%7 → 0x0002; 0xFFFF/0x0001 → 0xFFFF.
- DIV r2=0 and MOD r2=0 → result 0, o_dbz 1, o_valid at N+1; AND insn 0x5000 → result 0, o_illegal 1 at N+1.
- Backpressure: i_ready=0 for 5 cycles after o_valid → o_result constant, o_ready 0, a concurrent i_valid (ADD) is not accepted; release → IDLE next cycle, then the ADD is accepted.
- rst high at CALC cycle 5 of MUL → next cycle o_valid 0, o_ready 1, o_result 0; then ADDI (0x103D, imm −3) with r1=5 → 0x0002 at N+1.
